mmc_cmd_rx: RTL and testbench

//  Host-side CMD-line response receiver: the receive counterpart of the host command CRC7 generator.

---
 rtl/mmc_pkg.sv | 24 ++
 rtl/mmc_crc7_lfsr.sv | 37 +++
 rtl/mmc_cmd_rx.sv | 157 +++++++++++++++
 tb/tb_mmc_cmd_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc_pkg.sv
// Shared types and constants for the MMC/SD host CMD-line response receiver.
// Holds the receiver state encoding, frame lengths, CRC7 polynomial and a CRC coverage helper.
package mmc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECV       = 2'd2,
    DONE       = 2'd3
  } mmc_rx_state_e;

  localparam int           MMC_RESP_SHORT_BITS = 48;
  localparam int           MMC_RESP_LONG_BITS  = 136;
  localparam logic [6:0]   MMC_CRC7_POLY       = 7'h09;

  // R2 protects only the CID/CSD body, so its start, tx and reserved bits are skipped.
  function automatic logic crc_covers(input logic long_frame, input logic [7:0] idx);
    if (long_frame) begin
      return (idx >= 8'd8) && (idx <= 8'(MMC_RESP_LONG_BITS - 2));
    end
    return idx <= 8'(MMC_RESP_SHORT_BITS - 2);
  endfunction

endpackage

// File: rtl/mmc_crc7_lfsr.sv
// Serial CRC7 (x^7 + x^3 + 1) register, MSB-first, zero initialised.
// Feeding message plus its CRC leaves a zero remainder.
module mmc_crc7_lfsr
  import mmc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] rem_o
);

  logic [6:0] lfsr_q, lfsr_d;
  logic       fb;

  always_comb begin
    fb     = bit_i ^ lfsr_q[6];
    lfsr_d = lfsr_q;
    if (clr_i) begin
      lfsr_d = 7'h00;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[5:0], 1'b0} ^ (fb ? MMC_CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q <= 7'h00;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rem_o = lfsr_q;

endmodule

// File: rtl/mmc_cmd_rx.sv
// Host CMD-line response receiver: waits for the start bit, deserialises a 48/136-bit
// response, checks CRC7 and end bit, and flags NCR timeout.
//
//   state      | meaning
//   IDLE       | not armed; waits for start_i
//   WAIT_START | armed; counts bit strobes down towards NCR timeout
//   RECV       | shifting frame bits in, CRC running
//   DONE       | one-cycle done_o pulse, then IDLE
module mmc_cmd_rx
  import mmc_pkg::*;
#(
  parameter int TIMEOUT_BITS = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bit_en_i,
  input  logic         cmd_i,
  input  logic         start_i,
  input  logic         long_i,
  input  logic         crc_check_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         timeout_o,
  output logic         crc_err_o,
  output logic         end_err_o,
  output logic [5:0]   index_o,
  output logic [135:0] resp_o
);

  localparam logic [7:0] TO_LOAD    = 8'(TIMEOUT_BITS);
  localparam logic [7:0] LAST_SHORT = 8'(MMC_RESP_SHORT_BITS - 1);
  localparam logic [7:0] LAST_LONG  = 8'(MMC_RESP_LONG_BITS - 1);

  mmc_rx_state_e state_q, state_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic [135:0]  resp_q, resp_d;
  logic          long_q, long_d;
  logic          chk_q, chk_d;
  logic          timeout_q, timeout_d;
  logic          crc_err_q, crc_err_d;
  logic          end_err_q, end_err_d;
  logic          crc_clr, crc_en;
  logic [6:0]    crc_rem;
  logic [7:0]    frame_last;

  assign frame_last = long_q ? LAST_LONG : LAST_SHORT;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    resp_d    = resp_q;
    long_d    = long_q;
    chk_d     = chk_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d   = WAIT_START;
            bit_cnt_d = 8'd0;
            to_cnt_d  = TO_LOAD;
            resp_d    = '0;
            long_d    = long_i;
            chk_d     = crc_check_i;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
            crc_clr   = 1'b1;
          end
        end
        WAIT_START: begin
          if (bit_en_i) begin
            if (!cmd_i) begin
              state_d   = RECV;
              resp_d    = {resp_q[134:0], cmd_i};
              bit_cnt_d = 8'd1;
              crc_en    = crc_covers(long_q, 8'd0);
            end else if (to_cnt_q == 8'd1) begin
              state_d   = DONE;
              timeout_d = 1'b1;
            end else begin
              to_cnt_d = to_cnt_q - 8'd1;
            end
          end
        end
        RECV: begin
          if (bit_en_i) begin
            resp_d = {resp_q[134:0], cmd_i};
            crc_en = crc_covers(long_q, bit_cnt_q);
            if (bit_cnt_q == frame_last) begin
              // End bit: the CRC field has already been fed, so the remainder is final.
              state_d   = DONE;
              end_err_d = ~cmd_i;
              crc_err_d = chk_q & (crc_rem != 7'h00);
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 8'd0;
      to_cnt_q  <= 8'd0;
      resp_q    <= '0;
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      resp_q    <= resp_d;
      long_q    <= long_d;
      chk_q     <= chk_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
    end
  end

  mmc_crc7_lfsr u_crc7 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (cmd_i),
    .rem_o (crc_rem)
  );

  assign busy_o    = (state_q == WAIT_START) || (state_q == RECV);
  assign done_o    = (state_q == DONE);
  assign timeout_o = timeout_q;
  assign crc_err_o = crc_err_q;
  assign end_err_o = end_err_q;
  assign index_o   = resp_q[45:40];
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_mmc_cmd_rx.sv
// Bench for mmc_cmd_rx: table of fixed and random response frames checked against a
// polynomial-division CRC model, plus timeout, abort and reset sequences.
module tb_mmc_cmd_rx;

  typedef struct {
    logic [135:0] frame;
    logic         long_r;
    logic         crc_chk;
    logic         exp_crc;
    logic         exp_end;
    logic [5:0]   exp_idx;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bit_en, cmd, start, long_in, crc_check, abort;
  logic         busy, done, timeout, crc_err, end_err;
  logic [5:0]   index;
  logic [135:0] resp;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  mmc_cmd_rx #(.TIMEOUT_BITS(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bit_en_i    (bit_en),
    .cmd_i       (cmd),
    .start_i     (start),
    .long_i      (long_in),
    .crc_check_i (crc_check),
    .abort_i     (abort),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (timeout),
    .crc_err_o   (crc_err),
    .end_err_o   (end_err),
    .index_o     (index),
    .resp_o      (resp)
  );

  // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1 (0x89), by long division.
  function automatic logic [6:0] crc7_of(input logic [119:0] msg, input int n);
    logic [126:0] v;
    v = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic model_crc_err(input logic [135:0] f, input logic lg, input logic ck);
    logic [6:0] calc;
    if (lg) calc = crc7_of(f[127:8], 120);
    else    calc = crc7_of({80'b0, f[47:8]}, 40);
    return ck && (f[7:1] != calc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic b);
    repeat ($urandom_range(0, 2)) tick();
    bit_en = 1'b1;
    cmd    = b;
    tick();
    bit_en = 1'b0;
    cmd    = 1'($urandom_range(0, 1));
  endtask

  task automatic arm(input logic lg, input logic ck);
    start     = 1'b1;
    long_in   = lg;
    crc_check = ck;
    tick();
    start     = 1'b0;
    long_in   = 1'($urandom_range(0, 1));
    crc_check = 1'($urandom_range(0, 1));
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int len, w, d0;
    len = v.long_r ? 136 : 48;
    d0  = done_cnt;
    arm(v.long_r, v.crc_chk);
    chk({tag, "_busy_armed"}, 136'(busy), 136'(1));
    repeat ($urandom_range(0, 5)) strobe(1'b1);
    for (int i = len - 1; i >= 0; i--) strobe(v.frame[i]);
    w = 0;
    while (!done && w < 4) begin
      tick();
      w++;
    end
    chk({tag, "_done_latency"}, 136'(w), 136'(0));
    chk({tag, "_done"}, 136'(done), 136'(1));
    chk({tag, "_busy_at_done"}, 136'(busy), 136'(0));
    chk({tag, "_crc_err"}, 136'(crc_err), 136'(v.exp_crc));
    chk({tag, "_end_err"}, 136'(end_err), 136'(v.exp_end));
    chk({tag, "_timeout"}, 136'(timeout), 136'(0));
    chk({tag, "_resp"}, resp, v.frame);
    if (!v.long_r) chk({tag, "_index"}, 136'(index), 136'(v.exp_idx));
    tick();
    chk({tag, "_done_pulse"}, 136'(done), 136'(0));
    chk({tag, "_done_count"}, 136'(done_cnt - d0), 136'(1));
    chk({tag, "_resp_hold"}, resp, v.frame);
  endtask

  task automatic add(input logic [135:0] f, input logic lg, input logic ck,
                     input logic ec, input logic ee, input logic [5:0] ei);
    vec_t v;
    v.frame = f; v.long_r = lg; v.crc_chk = ck;
    v.exp_crc = ec; v.exp_end = ee; v.exp_idx = ei;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t         v;
    logic [127:0] r128;
    logic [119:0] cid;
    logic [39:0]  msg;
    logic [6:0]   crc;
    logic [135:0] f;
    logic         endb, ck;
    int           d0;

    rst_n = 1'b0; bit_en = 1'b0; cmd = 1'b1; start = 1'b0;
    long_in = 1'b0; crc_check = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 136'(busy), 136'(0));
    chk("reset_done", 136'(done), 136'(0));
    chk("reset_flags", 136'({timeout, crc_err, end_err}), 136'(0));
    chk("reset_resp", resp, 136'(0));
    rst_n = 1'b1;
    tick();

    // Fixed responses: CMD0-style, CMD8 echo, bad arg, bad end bit, R3 without CRC check.
    add(136'h40_0000_0000_95, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
    add(136'h48_0000_01AA_87, 1'b0, 1'b1, 1'b0, 1'b0, 6'h08);
    add(136'h40_0000_0001_95, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
    add(136'h40_0000_0000_94, 1'b0, 1'b1, 1'b0, 1'b1, 6'h00);
    add(136'h3F_80FF_8000_FF, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F);
    // R2 with a freshly computed CID CRC.
    r128 = {$urandom, $urandom, $urandom, $urandom};
    cid  = r128[119:0];
    f    = {8'h3F, cid, crc7_of(cid, 120), 1'b1};
    add(f, 1'b1, 1'b1, 1'b0, 1'b0, f[45:40]);
    // Random short frames with occasional CRC corruption and bad end bit.
    for (int k = 0; k < 14; k++) begin
      msg = {2'b00, 6'($urandom_range(0, 63)), 32'($urandom)};
      crc = crc7_of({80'b0, msg}, 40);
      if ($urandom_range(0, 2) == 0) crc = crc ^ 7'($urandom_range(1, 127));
      endb = ($urandom_range(0, 3) != 0);
      ck   = 1'($urandom_range(0, 1));
      f    = {88'b0, msg, crc, endb};
      add(f, 1'b0, ck, model_crc_err(f, 1'b0, ck), ~endb, msg[37:32]);
    end
    // Random long frames, some with a corrupted body bit.
    for (int k = 0; k < 4; k++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      cid  = r128[119:0];
      crc  = crc7_of(cid, 120);
      if (k[0]) cid[$urandom_range(0, 119)] ^= 1'b1;
      f    = {8'h3F, cid, crc, 1'b1};
      add(f, 1'b1, 1'b1, model_crc_err(f, 1'b1, 1'b1), 1'b0, f[45:40]);
    end

    for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // NCR timeout: 64 idle strobes, done_o on the cycle after the last one.
    arm(1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      strobe(1'b1);
      if (i < 64) chk($sformatf("to_early_done_%0d", i), 136'(done), 136'(0));
    end
    chk("to_done", 136'(done), 136'(1));
    chk("to_flag", 136'(timeout), 136'(1));
    chk("to_busy", 136'(busy), 136'(0));
    tick();
    chk("to_done_pulse", 136'(done), 136'(0));
    chk("to_flag_hold", 136'(timeout), 136'(1));

    // bit_en_i in IDLE is ignored, abort_i beats start_i.
    strobe(1'b0);
    chk("idle_strobe_busy", 136'(busy), 136'(0));
    chk("idle_strobe_resp", 136'(resp[0]), 136'(0));
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 136'(busy), 136'(0));

    // Abort at bit 20.
    d0 = done_cnt;
    arm(1'b0, 1'b1);
    for (int i = 47; i > 27; i--) strobe(vecs[0].frame[i]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 136'(busy), 136'(0));
    repeat (30) strobe(1'($urandom_range(0, 1)));
    chk("abort_no_done", 136'(done_cnt - d0), 136'(0));
    chk("abort_stays_idle", 136'(busy), 136'(0));

    // Reset at bit 30.
    arm(1'b0, 1'b1);
    for (int i = 47; i > 17; i--) strobe(vecs[0].frame[i]);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 136'(busy), 136'(0));
    chk("rst_resp", resp, 136'(0));
    chk("rst_flags", 136'({timeout, crc_err, end_err}), 136'(0));
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_done", 136'(done_cnt - d0), 136'(0));
    run_frame(vecs[0], "rearm");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
